// File: rtl/pacman_pkg.sv
// Shared definitions for the pacman movement path: direction words, grid
// defaults, mover FSM states and the tile-step arithmetic.
package pacman_pkg;

    localparam logic [15:0] DIR_LEFT  = 16'hFF00;
    localparam logic [15:0] DIR_RIGHT = 16'h0100;
    localparam logic [15:0] DIR_DOWN  = 16'h0001;
    localparam logic [15:0] DIR_UP    = 16'h00FF;
    localparam logic [15:0] DIR_STOP  = 16'h0000;

    localparam int unsigned GRID_W_DEFAULT = 28;
    localparam int unsigned GRID_H_DEFAULT = 31;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHK_NEXT,
        S_WAIT_NEXT,
        S_CHK_CUR,
        S_WAIT_CUR,
        S_COMMIT
    } state_t;

    typedef struct packed {
        logic [4:0] x;
        logic [4:0] y;
        logic       off;
    } target_t;

    function automatic logic dir_legal(input logic [15:0] d);
        return (d == DIR_LEFT) || (d == DIR_RIGHT) || (d == DIR_DOWN) ||
               (d == DIR_UP)   || (d == DIR_STOP);
    endfunction

    // Neighbouring tile in direction d; wraps horizontally only on the tunnel row.
    function automatic target_t step_target(input logic [4:0]   x,
                                            input logic [4:0]   y,
                                            input logic [15:0]  d,
                                            input int unsigned  gw,
                                            input int unsigned  gh,
                                            input int unsigned  trow);
        int      nx;
        int      ny;
        target_t t;
        nx = int'(x) + int'($signed(d[15:8]));
        ny = int'(y) + int'($signed(d[7:0]));
        if (int'(y) == int'(trow)) begin
            if (nx == -1)
                nx = int'(gw) - 1;
            else if (nx == int'(gw))
                nx = 0;
        end
        t.off = (nx < 0) || (nx >= int'(gw)) || (ny < 0) || (ny >= int'(gh));
        t.x   = 5'(nx);
        t.y   = 5'(ny);
        return t;
    endfunction

    function automatic logic [9:0] tile_addr(input target_t t, input int unsigned gw);
        return 10'(int'(t.y) * int'(gw) + int'(t.x));
    endfunction

endpackage

// File: rtl/pacman_mover_tick_gen.sv
// Terminal-count divider: pulses tick for one cycle every TERMINAL enabled cycles.
module tick_gen #(
    parameter int unsigned TERMINAL = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int unsigned CW = (TERMINAL > 1) ? $clog2(TERMINAL) : 1;

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == CW'(TERMINAL - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (tick)
            cnt <= '0;
        else if (en)
            cnt <= cnt + CW'(1);
    end

endmodule

// File: rtl/pacman_mover.sv
// Player position stage: queues requested turns, probes the wall ROM on each
// movement tick and commits one-tile steps.
module pacman_mover
    import pacman_pkg::*;
#(
    parameter int unsigned GRID_W         = GRID_W_DEFAULT,
    parameter int unsigned GRID_H         = GRID_H_DEFAULT,
    parameter int unsigned START_X        = 13,
    parameter int unsigned START_Y        = 23,
    parameter int unsigned TICKS_PER_STEP = 2500000,
    parameter int unsigned TUNNEL_ROW     = 14
) (
    input  logic        CLOCK_50,
    input  logic        resetn,
    input  logic [15:0] dir_in,
    input  logic        dir_valid,
    output logic [9:0]  wall_addr,
    input  logic        wall_rdata,
    output logic [4:0]  pos_x,
    output logic [4:0]  pos_y,
    output logic [15:0] cur_dir,
    output logic        moved,
    output logic        blocked
);

    state_t      state;
    logic [15:0] next_dir;
    logic [15:0] try_dir;
    target_t     tgt;
    target_t     tgt_next;
    target_t     tgt_cur;
    logic        cur_probe;
    logic        tick;

    tick_gen #(
        .TERMINAL (TICKS_PER_STEP)
    ) u_tick (
        .clk   (CLOCK_50),
        .rst_n (resetn),
        .en    (state == S_IDLE),
        .tick  (tick)
    );

    always_comb begin
        tgt_next  = step_target(pos_x, pos_y, next_dir, GRID_W, GRID_H, TUNNEL_ROW);
        tgt_cur   = step_target(pos_x, pos_y, cur_dir, GRID_W, GRID_H, TUNNEL_ROW);
        cur_probe = (cur_dir != DIR_STOP) && !tgt_cur.off;
    end

    // Targets and wall_addr are loaded on entry to each CHK state so the
    // registered ROM has its data ready in the following WAIT state.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            next_dir  <= DIR_STOP;
            try_dir   <= DIR_STOP;
            cur_dir   <= DIR_STOP;
            tgt       <= '0;
            wall_addr <= '0;
            pos_x     <= 5'(START_X);
            pos_y     <= 5'(START_Y);
            moved     <= 1'b0;
            blocked   <= 1'b0;
        end else begin
            moved <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (tick) begin
                        if (next_dir != DIR_STOP) begin
                            try_dir <= next_dir;
                            tgt     <= tgt_next;
                            if (!tgt_next.off)
                                wall_addr <= tile_addr(tgt_next, GRID_W);
                            state <= S_CHK_NEXT;
                        end else begin
                            tgt <= tgt_cur;
                            if (cur_probe)
                                wall_addr <= tile_addr(tgt_cur, GRID_W);
                            state <= S_CHK_CUR;
                        end
                    end
                end
                S_CHK_NEXT: begin
                    if (tgt.off) begin
                        tgt <= tgt_cur;
                        if (cur_probe)
                            wall_addr <= tile_addr(tgt_cur, GRID_W);
                        state <= S_CHK_CUR;
                    end else begin
                        state <= S_WAIT_NEXT;
                    end
                end
                S_WAIT_NEXT: begin
                    if (!wall_rdata) begin
                        cur_dir <= try_dir;
                        if (next_dir == try_dir)
                            next_dir <= DIR_STOP;
                        pos_x   <= tgt.x;
                        pos_y   <= tgt.y;
                        moved   <= 1'b1;
                        blocked <= 1'b0;
                        state   <= S_COMMIT;
                    end else begin
                        tgt <= tgt_cur;
                        if (cur_probe)
                            wall_addr <= tile_addr(tgt_cur, GRID_W);
                        state <= S_CHK_CUR;
                    end
                end
                S_CHK_CUR: begin
                    if ((cur_dir == DIR_STOP) || tgt.off) begin
                        blocked <= 1'b1;
                        state   <= S_IDLE;
                    end else begin
                        state <= S_WAIT_CUR;
                    end
                end
                S_WAIT_CUR: begin
                    if (!wall_rdata) begin
                        pos_x   <= tgt.x;
                        pos_y   <= tgt.y;
                        moved   <= 1'b1;
                        blocked <= 1'b0;
                        state   <= S_COMMIT;
                    end else begin
                        blocked <= 1'b1;
                        state   <= S_IDLE;
                    end
                end
                S_COMMIT: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase

            if (dir_valid && dir_legal(dir_in)) begin
                if (dir_in == DIR_STOP) begin
                    next_dir <= DIR_STOP;
                    cur_dir  <= DIR_STOP;
                end else begin
                    next_dir <= dir_in;
                end
            end
        end
    end

endmodule

// File: tb/tb_pacman_mover.sv
// Step-level reference bench for pacman_mover with a registered model wall ROM.
module tb_pacman_mover;

    localparam int T  = 8;
    localparam int GW = 28;
    localparam int GH = 31;
    localparam int TR = 14;

    logic        clk;
    logic        resetn;
    logic [15:0] dir_in;
    logic        dir_valid;
    logic [9:0]  wall_addr;
    logic        wall_rdata;
    logic [4:0]  pos_x;
    logic [4:0]  pos_y;
    logic [15:0] cur_dir;
    logic        moved;
    logic        blocked;

    bit walls [GH][GW];

    int          n_vec = 0;
    int          n_err = 0;
    int          mx, my;
    logic [15:0] mcur, mnext;
    bit          mblk;

    pacman_mover #(
        .GRID_W         (GW),
        .GRID_H         (GH),
        .START_X        (13),
        .START_Y        (23),
        .TICKS_PER_STEP (T),
        .TUNNEL_ROW     (TR)
    ) dut (
        .CLOCK_50   (clk),
        .resetn     (resetn),
        .dir_in     (dir_in),
        .dir_valid  (dir_valid),
        .wall_addr  (wall_addr),
        .wall_rdata (wall_rdata),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .cur_dir    (cur_dir),
        .moved      (moved),
        .blocked    (blocked)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_ff @(posedge clk)
        wall_rdata <= (int'(wall_addr) < GW * GH) ?
                      walls[int'(wall_addr) / GW][int'(wall_addr) % GW] : 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int sx(input logic [7:0] b);
        return int'($signed(b));
    endfunction

    function automatic bit legal(input logic [15:0] w);
        int dx, dy;
        dx = sx(w[15:8]);
        dy = sx(w[7:0]);
        return (dx == 0 && dy == 0) ||
               (dx == 0 && (dy == 1 || dy == -1)) ||
               (dy == 0 && (dx == 1 || dx == -1));
    endfunction

    function automatic void try_move(input logic [15:0] d, output int nx, output int ny,
                                     output bit off);
        nx = mx + sx(d[15:8]);
        ny = my + sx(d[7:0]);
        if (my == TR) begin
            if (nx < 0)        nx = GW - 1;
            else if (nx >= GW) nx = 0;
        end
        off = (nx < 0) || (nx >= GW) || (ny < 0) || (ny >= GH);
    endfunction

    function automatic void model_reset();
        mx = 13; my = 23; mcur = 16'h0000; mnext = 16'h0000; mblk = 1'b0;
    endfunction

    task automatic check_reset_values(input string tag);
        chk({tag, ".pos_x"}, 32'(pos_x), 32'd13);
        chk({tag, ".pos_y"}, 32'(pos_y), 32'd23);
        chk({tag, ".cur_dir"}, 32'(cur_dir), 32'h0);
        chk({tag, ".wall_addr"}, 32'(wall_addr), 32'h0);
        chk({tag, ".moved"}, 32'(moved), 32'h0);
        chk({tag, ".blocked"}, 32'(blocked), 32'h0);
    endtask

    // One movement period: request presented on the first idle cycle, then
    // T idle cycles plus however many FSM cycles the outcome needs.
    task automatic do_step(input logic [15:0] req, input bit v, input string tag);
        int nx, ny, f, seen, mcnt;
        bit off, mv, still, addr_moved;
        logic [9:0] a0;
        if (v && legal(req)) begin
            if (req == 16'h0000) begin
                mnext = 16'h0000;
                mcur  = 16'h0000;
            end else begin
                mnext = req;
            end
        end
        f = 0; mv = 1'b0; still = 1'b1;
        if (mnext != 16'h0000) begin
            try_move(mnext, nx, ny, off);
            if (off) f += 1;
            else begin
                still = 1'b0;
                f += 2;
                if (!walls[ny][nx]) begin
                    f += 1; mx = nx; my = ny; mcur = mnext; mnext = 16'h0000;
                    mv = 1'b1; mblk = 1'b0;
                end
            end
        end
        if (!mv) begin
            if (mcur == 16'h0000) begin
                f += 1; mblk = 1'b1;
            end else begin
                try_move(mcur, nx, ny, off);
                if (off) begin
                    f += 1; mblk = 1'b1;
                end else begin
                    still = 1'b0;
                    if (walls[ny][nx]) begin
                        f += 2; mblk = 1'b1;
                    end else begin
                        f += 3; mx = nx; my = ny; mv = 1'b1; mblk = 1'b0;
                    end
                end
            end
        end
        dir_in = req; dir_valid = v; a0 = wall_addr;
        seen = 0; mcnt = 0; addr_moved = 1'b0;
        for (int k = 1; k <= T + f; k++) begin
            @(posedge clk);
            @(negedge clk);
            dir_valid = 1'b0;
            dir_in    = 16'($urandom);
            if (moved === 1'b1) begin
                mcnt++;
                seen = k;
            end
            if (wall_addr !== a0) addr_moved = 1'b1;
        end
        chk({tag, ".pos_x"}, 32'(pos_x), 32'(mx));
        chk({tag, ".pos_y"}, 32'(pos_y), 32'(my));
        chk({tag, ".cur_dir"}, 32'(cur_dir), 32'(mcur));
        chk({tag, ".blocked"}, 32'(blocked), 32'(mblk));
        chk({tag, ".moved_pulses"}, 32'(mcnt), 32'(mv));
        if (mv) chk({tag, ".moved_cycle"}, 32'(seen), 32'(T + f - 1));
        if (still) chk({tag, ".no_rom_read"}, 32'(addr_moved), 32'h0);
    endtask

    task automatic reset_in_wait_cur();
        int mcnt;
        mcnt = 0;
        dir_valid = 1'b0;
        for (int k = 1; k <= T + 1; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (moved === 1'b1) mcnt++;
        end
        resetn = 1'b0;
        #1;
        check_reset_values("rst_mid");
        @(posedge clk);
        @(negedge clk);
        if (moved === 1'b1) mcnt++;
        chk("rst_mid.moved_pulses", 32'(mcnt), 32'h0);
        resetn = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [15:0] rq;
        int          r;
        resetn = 1'b0; dir_in = 16'h0000; dir_valid = 1'b0;
        foreach (walls[y, x]) walls[y][x] = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        check_reset_values("reset");
        @(negedge clk);
        resetn = 1'b1;

        do_step(16'h0000, 1'b0, "idle_tick");
        do_step(16'h0100, 1'b1, "right1");
        do_step(16'h0000, 1'b0, "right2");

        walls[22][15] = 1'b1;
        walls[22][16] = 1'b1;
        do_step(16'h00FF, 1'b1, "queued1");
        do_step(16'h0000, 1'b0, "queued2");
        do_step(16'h0000, 1'b0, "turn");
        chk("turn.cur_dir_up", 32'(cur_dir), 32'h00FF);

        do_step(16'h01FF, 1'b1, "diagonal");
        do_step(16'h0200, 1'b1, "mag2");
        for (int i = 0; i < 6; i++) do_step(16'h0000, 1'b0, "up_run");
        chk("row14.pos_y", 32'(pos_y), 32'd14);

        do_step(16'hFF00, 1'b1, "left_run");
        for (int i = 0; i < 17; i++) do_step(16'h0000, 1'b0, "left_run");
        chk("tunnel.pos_x", 32'(pos_x), 32'd27);

        do_step(16'h00FF, 1'b1, "up_row5");
        for (int i = 0; i < 8; i++) do_step(16'h0000, 1'b0, "up_row5");
        chk("row5.pos_y", 32'(pos_y), 32'd5);
        do_step(16'h0000, 1'b1, "stop");
        do_step(16'h0100, 1'b1, "offgrid");
        chk("offgrid.blocked", 32'(blocked), 32'h1);
        do_step(16'h0000, 1'b1, "stop2");
        do_step(16'hFF00, 1'b1, "pre_rst");
        reset_in_wait_cur();
        do_step(16'h0000, 1'b0, "post_rst");

        for (int i = 0; i < 60; i++) begin
            foreach (walls[y, x]) walls[y][x] = ($urandom_range(0, 3) == 0);
            r = $urandom_range(0, 9);
            case (r)
                0, 1:    rq = 16'hFF00;
                2, 3:    rq = 16'h0100;
                4, 5:    rq = 16'h00FF;
                6, 7:    rq = 16'h0001;
                8:       rq = 16'h0000;
                default: rq = 16'($urandom);
            endcase
            do_step(rq, ($urandom_range(0, 3) != 0), "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pacman_mover.md
# pacman_mover

Sequential position-update stage directly downstream of the direction-decode block. It consumes the 16-bit packed direction word (signed dx in [15:8], signed dy in [7:0]), queues it as the player's requested turn, and on each movement tick checks the maze wall ROM. It then commits a one-tile step on the grid and drives the player tile coordinates to the game-graphics module.

## Interface
Parameters:
- GRID_W, 28, maze width in tiles
- GRID_H, 31, maze height in tiles
- START_X, 13, reset tile column
- START_Y, 23, reset tile row
- TICKS_PER_STEP, 2500000, clock cycles per movement tick (20 Hz at 50 MHz); must be >= 8
- TUNNEL_ROW, 14, only row where horizontal wrap-around is permitted

Ports:
- CLOCK_50  in  1  system clock; single clock domain
- resetn  in  1  asynchronous, active-low reset
- dir_in  in  16  packed direction {dx[7:0], dy[7:0]}, two's complement; LEFT=16'hFF00, RIGHT=16'h0100, DOWN=16'h0001, UP=16'h00FF
- dir_valid  in  1  dir_in qualifier, sampled every cycle
- wall_addr  out  10  wall ROM address = y*GRID_W + x
- wall_rdata  in  1  ROM data, 1 = wall; valid one cycle after wall_addr (registered ROM)
- pos_x  out  5  current tile column
- pos_y  out  5  current tile row
- cur_dir  out  16  direction currently being travelled, same packing as dir_in
- moved  out  1  one-cycle pulse on a committed step
- blocked  out  1  level; high when the last tick produced no movement

## Operation
- Legal direction: exactly one of dx, dy is nonzero and its value is +1 or -1. The four constants above plus 16'h0000 (stop) are the only words accepted.
- Illegal words are ignored. These include diagonals such as 16'h01FF, and magnitudes other than 1.
- Request latch: when dir_valid=1 and dir_in is legal and nonzero, next_dir <= dir_in. When dir_in=16'h0000, both next_dir and cur_dir clear.
- Tick counter: counts 0..TICKS_PER_STEP-1 while the FSM is in IDLE, then raises an internal tick and resets to 0.
- FSM states: IDLE, CHK_NEXT, WAIT_NEXT, CHK_CUR, WAIT_CUR, COMMIT.
  - IDLE -> CHK_NEXT on tick if next_dir != 0; otherwise -> CHK_CUR.
  - CHK_NEXT: compute target = pos + next_dir and drive wall_addr; -> WAIT_NEXT.
  - WAIT_NEXT: if wall_rdata=0, cur_dir <= next_dir, next_dir <= 0, -> COMMIT. Otherwise -> CHK_CUR; next_dir is retained (queued turn).
  - CHK_CUR: if cur_dir=0, set blocked=1 and -> IDLE. Otherwise drive wall_addr for pos + cur_dir; -> WAIT_CUR.
  - WAIT_CUR: if wall_rdata=0 -> COMMIT. Otherwise blocked=1 and -> IDLE; cur_dir is retained.
  - COMMIT: pos <= target, moved=1, blocked=0; -> IDLE.
- Arithmetic: dx/dy are sign-extended to 6 bits and added to the 5-bit position.
- Horizontal wrap, on TUNNEL_ROW only: x = -1 maps to GRID_W-1, and x = GRID_W maps to 0.
- Off-grid target elsewhere (x outside 0..GRID_W-1, or y outside 0..GRID_H-1): treated as a wall without issuing a ROM read. Take the wall path one cycle early, with no WAIT state.
- Simultaneous events: a request latched in the same cycle as a CHK_NEXT is not used until the next tick. The latch still updates.

## Timing
- Reset values: pos_x=START_X, pos_y=START_Y, cur_dir=0, next_dir=0, wall_addr=0, moved=0, blocked=0, state=IDLE, counter=0.
- resetn asserted mid-sequence aborts immediately. No step commits; the next step occurs TICKS_PER_STEP cycles after release.
- Latency, tick to moved: 3 cycles on the next_dir-success path, 5 cycles on the fallback-to-cur_dir path.
- pos_x/pos_y update in the same cycle moved is high. All outputs are registered.
- Since the counter is frozen outside IDLE, the step period is TICKS_PER_STEP + FSM cycles. This is accepted.

## Structure
- Shared package `pacman_pkg` holds:
  - the LEFT/RIGHT/UP/DOWN/STOP constants, shared with the decode block
  - the GRID_W/GRID_H defaults
  - the FSM state encoding
  - a function for the legal-direction check
- Sub-module `tick_gen`: parameterised terminal-count divider with an enable input. Everything else stays flat.

## Test plan
The bench uses TICKS_PER_STEP=8 and a model ROM.
- Reset at start, then one tick with no input -> pos=(13,23), blocked=1, moved never pulses.
- dir_in=16'h0100 with dir_valid, open maze -> moved each tick; pos_x 13->14->15; cur_dir=16'h0100.
- Queued turn: travelling RIGHT, UP requested, wall above for 2 ticks -> moves right twice, then turns. cur_dir becomes 16'h00FF and next_dir clears.
- dir_in=16'h01FF (diagonal) -> ignored; cur_dir and next_dir unchanged.
- Tunnel: pos=(0,14) moving LEFT -> pos_x=27. Same move at row 5 -> blocked=1 with no ROM read.
- resetn pulsed during WAIT_CUR -> no moved pulse; outputs return to reset values.
